// File: rtl/list_walk_accumulator.sv
// Walks a linked list in an external synchronous RAM (node = {next, data} at p, p+1)
// and reduces the payloads by sum, count, max or min.
module list_walk_accumulator #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int SUM_W     = 16,
    parameter int MAX_NODES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] head,
    input  logic [1:0]        mode,
    output logic              busy,
    output logic              done,
    output logic [SUM_W-1:0]  result,
    output logic [15:0]       node_count,
    output logic              overflow,
    output logic              error,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_REQ_DATA = 3'd1;
    localparam logic [2:0] S_REQ_NEXT = 3'd2;
    localparam logic [2:0] S_CHECK    = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    localparam logic [1:0] M_SUM   = 2'd0;
    localparam logic [1:0] M_COUNT = 2'd1;
    localparam logic [1:0] M_MAX   = 2'd2;
    localparam logic [1:0] M_MIN   = 2'd3;

    localparam logic [ADDR_W-1:0] NULL_PTR = '1;
    localparam logic [15:0]       MAX_CNT  = 16'(MAX_NODES);
    localparam logic [DATA_W-1:0] DATA_ONES = '1;
    localparam logic [SUM_W-1:0]  MIN_INIT = SUM_W'(DATA_ONES);

    logic [2:0]        state;
    logic [ADDR_W-1:0] ptr;
    logic [1:0]        run_mode;
    logic [SUM_W-1:0]  acc;
    logic [15:0]       cnt;
    logic              ovf;

    logic [SUM_W-1:0]  data_ext;
    logic [SUM_W:0]    sum_full;
    logic [SUM_W-1:0]  acc_upd;
    logic [SUM_W-1:0]  acc_init;
    logic [ADDR_W-1:0] nxt;
    logic              sum_carry;

    assign data_ext  = SUM_W'(mem_rdata);
    assign sum_full  = {1'b0, acc} + {1'b0, data_ext};
    assign sum_carry = sum_full[SUM_W];
    assign nxt       = mem_rdata[ADDR_W-1:0];
    assign acc_init  = (mode == M_MIN) ? MIN_INIT : '0;

    // Saturate on carry; once all-ones, further adds keep it there.
    always_comb begin
        acc_upd = acc;
        case (run_mode)
            M_SUM:   acc_upd = sum_carry ? '1 : sum_full[SUM_W-1:0];
            M_COUNT: acc_upd = SUM_W'(cnt + 16'd1);
            M_MAX:   acc_upd = (data_ext > acc) ? data_ext : acc;
            M_MIN:   acc_upd = (data_ext < acc) ? data_ext : acc;
            default: acc_upd = acc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            ptr        <= '0;
            run_mode   <= M_SUM;
            acc        <= '0;
            cnt        <= '0;
            ovf        <= 1'b0;
            result     <= '0;
            node_count <= '0;
            overflow   <= 1'b0;
            error      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        ptr        <= head;
                        run_mode   <= mode;
                        acc        <= acc_init;
                        cnt        <= '0;
                        ovf        <= 1'b0;
                        node_count <= '0;
                        overflow   <= 1'b0;
                        error      <= 1'b0;
                        if (head == NULL_PTR) begin
                            result <= acc_init;
                            state  <= S_DONE;
                        end else begin
                            state  <= S_REQ_DATA;
                        end
                    end
                end
                S_REQ_DATA: state <= S_REQ_NEXT;
                S_REQ_NEXT: begin
                    acc   <= acc_upd;
                    cnt   <= cnt + 16'd1;
                    if (run_mode == M_SUM && sum_carry)
                        ovf <= 1'b1;
                    state <= S_CHECK;
                end
                S_CHECK: begin
                    // End of list wins over the loop guard on the last allowed node.
                    if (nxt == NULL_PTR || cnt == MAX_CNT) begin
                        result     <= acc;
                        node_count <= cnt;
                        overflow   <= ovf;
                        error      <= (nxt != NULL_PTR);
                        state      <= S_DONE;
                    end else begin
                        ptr   <= nxt;
                        state <= S_REQ_DATA;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy     = (state == S_REQ_DATA) || (state == S_REQ_NEXT) || (state == S_CHECK);
        done     = (state == S_DONE);
        mem_rd   = (state == S_REQ_DATA) || (state == S_REQ_NEXT);
        mem_addr = '0;
        if (state == S_REQ_DATA)
            mem_addr = ptr + 1'b1;
        else if (state == S_REQ_NEXT)
            mem_addr = ptr;
    end

endmodule
